// File: rtl/mem_pkg.sv
// Shared widths, FSM states and grant encoding for the line-fill server.
// Storage and arbiter files import this package.
package mem_pkg;

    localparam int LINE_BITS = 128;
    localparam int ADDR_BITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lfs_state_e;

    // Also used as bit positions in the one-hot grant vector.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

endpackage

// File: rtl/line_arbiter.sv
// Picks one of the I-side / D-side fill requests, producing a one-hot grant.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller only acts on the grant while idle.
module line_arbiter
    import mem_pkg::*;
(
    input  logic       ic_req,
    input  logic       dc_req,
    input  logic       prefer_d,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (ic_req && dc_req) begin
            if (prefer_d) gnt[GNT_D] = 1'b1;
            else          gnt[GNT_I] = 1'b1;
        end else if (dc_req) begin
            gnt[GNT_D] = 1'b1;
        end else if (ic_req) begin
            gnt[GNT_I] = 1'b1;
        end
    end

endmodule

// File: rtl/line_fill_server.sv
// Shared I/D line-fill memory with write-back port; LFS_ROUND_ROBIN_EN enables fair arbitration.
// Latency: valid LATENCY cycles after grant; write-backs commit the same cycle.
// Backpressure: one fill in flight, new requests wait in IDLE; write-backs never stall.
module line_fill_server
    import mem_pkg::*;
#(
    parameter int LINE_BITS = mem_pkg::LINE_BITS,
    parameter int ADDR_BITS = mem_pkg::ADDR_BITS,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Ic_mem_req,
    input  logic [ADDR_BITS-1:0] Ic_mem_addr,
    output logic [LINE_BITS-1:0] F_mem_inst,
    output logic                 F_mem_valid,
    input  logic                 Dc_mem_req,
    input  logic [ADDR_BITS-1:0] Dc_mem_addr,
    output logic [LINE_BITS-1:0] MEM_data_line,
    output logic                 MEM_mem_valid,
    input  logic                 Dc_wb_we,
    input  logic [ADDR_BITS-1:0] Dc_wb_addr,
    input  logic [LINE_BITS-1:0] Dc_wb_wline,
    output logic                 busy
);

    localparam int IDX = $clog2(DEPTH);

    lfs_state_e           state, state_n;
    gnt_e                 side, side_n;
    logic [3:0]           cnt, cnt_n;
    logic [IDX-1:0]       addr_q, addr_n;
    logic [1:0]           gnt;
    logic                 prefer_d;
    logic                 enter_resp;
    logic [IDX-1:0]       wb_idx;
    logic [LINE_BITS-1:0] rd_line;
    logic [LINE_BITS-1:0] mem [DEPTH];
    logic                 unused_addr_bits;

    assign wb_idx           = Dc_wb_addr[IDX-1:0];
    assign unused_addr_bits = ^{Ic_mem_addr, Dc_mem_addr, Dc_wb_addr};
    assign busy             = (state != IDLE);

`ifdef LFS_ROUND_ROBIN_EN
    // Pointer moves only on contested grants, so a lone requester never steals the turn.
    logic rr_prefer_d;
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_prefer_d <= 1'b1;
        end else if (state == IDLE && Ic_mem_req && Dc_mem_req) begin
            rr_prefer_d <= gnt[GNT_I];
        end
    end
    assign prefer_d = rr_prefer_d;
`else
    assign prefer_d = 1'b1;
`endif

    line_arbiter u_arb (
        .ic_req   (Ic_mem_req),
        .dc_req   (Dc_mem_req),
        .prefer_d (prefer_d),
        .gnt      (gnt)
    );

    always_comb begin
        state_n = state;
        side_n  = side;
        cnt_n   = cnt;
        addr_n  = addr_q;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    side_n  = gnt[GNT_D] ? GNT_D : GNT_I;
                    addr_n  = gnt[GNT_D] ? Dc_mem_addr[IDX-1:0] : Ic_mem_addr[IDX-1:0];
                    cnt_n   = 4'(LATENCY - 1);
                    state_n = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) state_n = RESP;
            end
            default: state_n = IDLE;
        endcase
    end

    assign enter_resp = (state_n == RESP) && (state != RESP);

    // Read on the edge that enters RESP; a write-back in that same cycle wins.
    always_comb begin
        rd_line = mem[addr_n];
        if (Dc_wb_we && wb_idx == addr_n) rd_line = Dc_wb_wline;
    end

    always_ff @(posedge clk) begin
        if (Dc_wb_we) mem[wb_idx] <= Dc_wb_wline;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            side          <= GNT_D;
            cnt           <= '0;
            addr_q        <= '0;
            F_mem_valid   <= 1'b0;
            MEM_mem_valid <= 1'b0;
            F_mem_inst    <= '0;
            MEM_data_line <= '0;
        end else begin
            state         <= state_n;
            side          <= side_n;
            cnt           <= cnt_n;
            addr_q        <= addr_n;
            F_mem_valid   <= enter_resp && (side_n == GNT_I);
            MEM_mem_valid <= enter_resp && (side_n == GNT_D);
            if (enter_resp && side_n == GNT_I) F_mem_inst    <= rd_line;
            if (enter_resp && side_n == GNT_D) MEM_data_line <= rd_line;
        end
    end

endmodule

// File: tb/tb_line_fill_server.sv
// Directed bench for line_fill_server: LATENCY=3 instance plus a LATENCY=1 instance.
module tb_line_fill_server;

    typedef struct {
        bit           d;
        logic [127:0] line;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_req, dc_req, wb_we;
    logic [9:0]   ic_addr, dc_addr, wb_addr;
    logic [127:0] wb_line;
    logic [127:0] f_inst, m_line;
    logic         f_valid, m_valid, busy;

    logic         i1_req, d1_req;
    logic [10:0]  i1_addr, d1_addr;
    logic [127:0] f1_inst, m1_line;
    logic         f1_valid, m1_valid, busy1;

    exp_t         sb[$];
    logic [127:0] ref_mem [1024];
    int           tests_run = 0;
    int           tests_failed = 0;
    int           cyc = 0;
    int           t0;

    always #5 clk = ~clk;

    line_fill_server #(.LATENCY(3)) u_dut (
        .clk(clk), .rst(rst),
        .Ic_mem_req(ic_req), .Ic_mem_addr(ic_addr),
        .F_mem_inst(f_inst), .F_mem_valid(f_valid),
        .Dc_mem_req(dc_req), .Dc_mem_addr(dc_addr),
        .MEM_data_line(m_line), .MEM_mem_valid(m_valid),
        .Dc_wb_we(wb_we), .Dc_wb_addr(wb_addr), .Dc_wb_wline(wb_line),
        .busy(busy)
    );

    line_fill_server #(.ADDR_BITS(11), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .Ic_mem_req(i1_req), .Ic_mem_addr(i1_addr),
        .F_mem_inst(f1_inst), .F_mem_valid(f1_valid),
        .Dc_mem_req(d1_req), .Dc_mem_addr(d1_addr),
        .MEM_data_line(m1_line), .MEM_mem_valid(m1_valid),
        .Dc_wb_we(wb_we), .Dc_wb_addr({1'b0, wb_addr}), .Dc_wb_wline(wb_line),
        .busy(busy1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_line(input int a, input logic [127:0] v);
        wb_we   = 1'b1;
        wb_addr = 10'(a);
        wb_line = v;
        ref_mem[a % 1024] = v;
        step();
        wb_we = 1'b0;
    endtask

    task automatic push(input bit d, input logic [127:0] line, input int due);
        exp_t e;
        e.d = d;
        e.line = line;
        e.due = due;
        sb.push_back(e);
    endtask

    // Any valid with an empty scoreboard, a wrong side or a wrong cycle is reported.
    task automatic wait_resp(input int budget);
        exp_t e;
        for (int i = 0; i < budget; i++) begin
            if (f_valid || m_valid) begin
                if (sb.size() == 0) begin
                    chk("stray_valid", 128'({m_valid, f_valid}), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("resp_side", 128'({m_valid, f_valid}), e.d ? 128'(2'b10) : 128'(2'b01));
                    chk("resp_data", e.d ? m_line : f_inst, e.line);
                    chk("resp_cycle", 128'(cyc), 128'(e.due));
                    if (e.d) dc_req = 1'b0;
                    else     ic_req = 1'b0;
                end
            end
            step();
        end
        chk("sb_drained", 128'(sb.size()), 128'(0));
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        ic_req = 1'b0; dc_req = 1'b0; wb_we = 1'b0;
        ic_addr = '0; dc_addr = '0; wb_addr = '0; wb_line = '0;
        i1_req = 1'b0; d1_req = 1'b0; i1_addr = '0; d1_addr = '0;
        repeat (3) step();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_f_valid", 128'(f_valid), 128'(0));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_f_inst", f_inst, 128'(0));
        chk("rst_m_line", m_line, 128'(0));
        chk("rst_l1_valids", 128'({f1_valid, m1_valid, busy1}), 128'(0));
        rst = 1'b1;
        step();

        write_line(5, {16{8'hA5}});
        for (int a = 2; a < 24; a++) begin
            if (a != 5) write_line(a, {4{32'hC0DE0000 + 32'(a)}});
        end

        // I-side fill of a freshly written line
        ic_addr = 10'd5; ic_req = 1'b1; t0 = cyc;
        push(1'b0, ref_mem[5], t0 + 3);
        step();
        chk("busy_wait", 128'(busy), 128'(1));
        wait_resp(8);
        chk("f_hold", f_inst, {16{8'hA5}});

        // Simultaneous pair: D first, I follows after the D turnaround
        dc_addr = 10'd3; ic_addr = 10'd20; dc_req = 1'b1; ic_req = 1'b1; t0 = cyc;
        push(1'b1, ref_mem[3], t0 + 3);
        push(1'b0, ref_mem[20], t0 + 7);
        wait_resp(12);

        dc_addr = 10'd20; ic_addr = 10'd3; dc_req = 1'b1; ic_req = 1'b1; t0 = cyc;
`ifdef LFS_ROUND_ROBIN_EN
        push(1'b0, ref_mem[3], t0 + 3);
        push(1'b1, ref_mem[20], t0 + 7);
`else
        push(1'b1, ref_mem[20], t0 + 3);
        push(1'b0, ref_mem[3], t0 + 7);
`endif
        wait_resp(12);

        // Write-back landing while the D fill is in flight
        dc_addr = 10'd9; dc_req = 1'b1; t0 = cyc;
        push(1'b1, 128'h1234, t0 + 3);
        step();
        step();
        write_line(9, 128'h1234);
        wait_resp(6);

        // Reset mid-fill: nothing returns, storage survives
        dc_addr = 10'd7; dc_req = 1'b1;
        step();
        chk("busy_granted", 128'(busy), 128'(1));
        rst = 1'b0; dc_req = 1'b0;
        step();
        chk("busy_after_rst", 128'(busy), 128'(0));
        chk("m_valid_after_rst", 128'(m_valid), 128'(0));
        chk("f_inst_cleared", f_inst, 128'(0));
        rst = 1'b1;
        wait_resp(8);

        dc_addr = 10'd7; dc_req = 1'b1;
        push(1'b1, ref_mem[7], cyc + 3);
        wait_resp(8);
        ic_addr = 10'd5; ic_req = 1'b1;
        push(1'b0, ref_mem[5], cyc + 3);
        wait_resp(8);

        // LATENCY=1 with an out-of-range index wrapping onto line 7
        i1_addr = 11'd1031; i1_req = 1'b1;
        chk("l1_not_early", 128'(f1_valid), 128'(0));
        step();
        chk("l1_f_valid", 128'(f1_valid), 128'(1));
        chk("l1_f_inst", f1_inst, ref_mem[7]);
        chk("l1_m_quiet", 128'(m1_valid), 128'(0));
        i1_req = 1'b0;
        step();
        chk("l1_f_single", 128'(f1_valid), 128'(0));

        // LATENCY=1 with a same-cycle write-back to the requested line
        d1_addr = 11'd2; d1_req = 1'b1;
        write_line(2, 128'hFEED_0002);
        chk("l1_m_valid", 128'(m1_valid), 128'(1));
        chk("l1_m_fwd", m1_line, 128'hFEED_0002);
        d1_req = 1'b0;
        step();
        chk("l1_m_single", 128'(m1_valid), 128'(0));
        chk("l1_m_hold", m1_line, 128'hFEED_0002);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
